rf_seq_ctrl: RTL and testbench
==============================

Name: rf_seq_ctrl

Overview:
- Multi-cycle sequencer that drives the 8x16 register file and the ALU.
- Accepts one 16-bit instruction at a time over a valid/ready handshake and decodes it.
- Sequences the register-file read selects (sel_A/sel_B), holds them for the ALU execute window, then issues a single-cycle write (in/enable) to the destination register.
- Sits between the instruction source and the register file / ALU datapath.

Parameters:
- N, 16, datapath/instruction width; instruction format is fixed for N=16.
- EXEC_CYCLES, 1, ALU execute cycles with sel_A/sel_B held stable; legal range 1..15.
- CW, 4, width of the execute-wait counter; must satisfy 2^CW > EXEC_CYCLES.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset. One clock; reset is synchronous and active-high: rst_n=1 at a rising edge resets the block.
- instr  in  N  instruction word [15:12]=opcode, [11:9]=rd, [8:6]=ra, [5:3]=rb, [2:0]=unused.
- instr_valid  in  1  instr is valid this cycle.
- instr_ready  out  1  block can accept; high only in IDLE.
- sel_A  out  3  register file port A select.
- sel_B  out  3  register file port B select.
- alu_op  out  4  opcode forwarded to ALU.
- wb_sel  out  1  write-data mux select: 0=ALU result, 1=immediate.
- imm  out  N  zero-extended {instr[8:3]} for LDI.
- in  out  3  register file write address (decoder input).
- enable  out  1  register file write enable, one cycle per writing instruction.
- done  out  1  one-cycle pulse at instruction retirement.
- halted  out  1  high in HALT state.

Behaviour:
- Instruction register IR is captured on instr_valid & instr_ready. The handshake is the only capture point; instr is ignored otherwise.
- Opcodes:
  - 0x0 NOP: no write.
  - 0x1..0xD ALU ops: write rd with the ALU result.
  - 0xE LDI: write rd with imm.
  - 0xF HALT.
- States and transitions: IDLE, READ, EXEC, WRITE, HALT.
  - IDLE -> READ on handshake.
  - READ -> IDLE (NOP, done=1 in READ).
  - READ -> WRITE (LDI).
  - READ -> HALT (HALT, done=1 in READ).
  - READ -> EXEC (ALU ops); counter loaded to 0.
  - EXEC stays until counter == EXEC_CYCLES-1, then -> WRITE.
  - WRITE -> IDLE always.
  - HALT is terminal until reset; instr_ready=0 there.
- Outputs are Moore, decoded from state and IR; no combinational path from instr or instr_valid to any output.
- sel_A=IR.ra and sel_B=IR.rb in READ and EXEC, and in WRITE so the ALU result stays stable through the write edge. Both are 0 otherwise.
- alu_op=IR.opcode in READ/EXEC/WRITE, else 0.
- WRITE cycle:
  - enable=1, in=IR.rd, done=1.
  - wb_sel=1 only for LDI.
  - imm valid from READ through WRITE.
- Timing for an ALU op accepted at cycle T:
  - READ at T+1.
  - EXEC at T+2 .. T+1+EXEC_CYCLES.
  - WRITE at T+2+EXEC_CYCLES; the register updates at the end of that cycle.
  - IDLE at T+3+EXEC_CYCLES.
- Timing for other opcodes accepted at T:
  - LDI: WRITE at T+2.
  - NOP: retires at T+1.
- Minimum one IDLE cycle between instructions; there is no back-to-back acceptance.
- Reset values, including reset asserted mid-operation:
  - State=IDLE, IR=0, counter=0.
  - enable=0, done=0, halted=0.
  - sel_A=sel_B=in=alu_op=wb_sel=0, imm=0.
  - instr_ready=1 from the first cycle after reset.
- A write in progress when reset is asserted is suppressed: enable=0 in the reset cycle.
- rd = ra or rb is legal. The read uses the old value and the new value is visible after the WRITE edge.
- Writing r0 is ordinary; r0 is not hardwired.

Decomposition:
- Shared package rf_ctrl_pkg holds:
  - opcode constants OP_NOP=4'h0, OP_LDI=4'hE, OP_HALT=4'hF;
  - field bit positions;
  - state encoding constants (3-bit).
- One sub-module: rf_instr_decode.
  - Combinational, IR -> {rd, ra, rb, opcode, imm, is_nop, is_ldi, is_halt, is_alu}.
  - Instantiated once inside rf_seq_ctrl.
- FSM and counter live in the top.

Test Plan:
- Reset held 3 cycles then released -> all outputs 0, instr_ready=1, halted=0.
- ADD r3,r1,r2 (instr=0x1650), EXEC_CYCLES=2, accepted at T:
  - sel_A=1, sel_B=2 over T+1..T+4.
  - enable=1, in=3, done=1 exactly at T+4.
  - instr_ready=1 again at T+5.
- LDI r5,#0x2A (instr=0xEB50) -> WRITE at T+2 with in=5, wb_sel=1, imm=0x002A, enable=1; no EXEC cycles.
- NOP then HALT:
  - NOP gives done at T+1 and never enable.
  - HALT gives done at T'+1, then halted=1 and instr_ready=0 for 20 cycles while instr_valid=1.
  - Reset then restores IDLE.
- instr_valid held high continuously with 3 queued instructions -> exactly one accept per instruction, only in IDLE cycles, in order, and enable count matches the writing instructions.
- Reset asserted in the WRITE cycle of an ADD -> enable=0 that cycle, next state IDLE, register not written.

Source files
------------

// File: rtl/rf_seq_ctrl_pkg.sv
// Shared definitions for the register-file sequencer: opcode constants,
// instruction field positions and FSM state encoding.
package rf_ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Instruction field bit positions (16-bit format)
  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RA_MSB  = 8;
  localparam int unsigned RA_LSB  = 6;
  localparam int unsigned RB_MSB  = 5;
  localparam int unsigned RB_LSB  = 3;
  localparam int unsigned IMM_MSB = 8;
  localparam int unsigned IMM_LSB = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  typedef enum logic [2:0] {
    StIdle  = ST_IDLE,
    StRead  = ST_READ,
    StExec  = ST_EXEC,
    StWrite = ST_WRITE,
    StHalt  = ST_HALT
  } state_e;

endpackage

// File: rtl/rf_seq_ctrl_if.sv
// Bus between the instruction source, the sequencer and the register
// file / ALU datapath.
//   instr, instr_valid, instr_ready : instruction handshake
//   sel_A, sel_B, alu_op            : read selects and ALU opcode
//   wb_sel, imm, in, enable         : write-back controls
//   done, halted                    : retirement pulse and halt status
interface rf_seq_ctrl_if #(
  parameter int unsigned N = 16
);
  logic [N-1:0] instr;
  logic         instr_valid;
  logic         instr_ready;
  logic [2:0]   sel_A;
  logic [2:0]   sel_B;
  logic [3:0]   alu_op;
  logic         wb_sel;
  logic [N-1:0] imm;
  logic [2:0]   in;
  logic         enable;
  logic         done;
  logic         halted;

  // master: instruction source / datapath side
  modport master (
    output instr, instr_valid,
    input  instr_ready, sel_A, sel_B, alu_op, wb_sel, imm, in, enable, done, halted
  );

  // slave: the sequencer
  modport slave (
    input  instr, instr_valid,
    output instr_ready, sel_A, sel_B, alu_op, wb_sel, imm, in, enable, done, halted
  );
endinterface

// File: rtl/rf_instr_decode.sv
// Combinational instruction decoder.
//   i_ir     : instruction word
//   o_rd/ra/rb, o_opcode, o_imm : extracted fields (imm zero-extended)
//   o_is_*   : opcode class flags
module rf_instr_decode
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] i_ir,
  output logic [2:0]   o_rd,
  output logic [2:0]   o_ra,
  output logic [2:0]   o_rb,
  output logic [3:0]   o_opcode,
  output logic [N-1:0] o_imm,
  output logic         o_is_nop,
  output logic         o_is_ldi,
  output logic         o_is_halt,
  output logic         o_is_alu
);
  always_comb begin
    o_opcode  = i_ir[OP_MSB:OP_LSB];
    o_rd      = i_ir[RD_MSB:RD_LSB];
    o_ra      = i_ir[RA_MSB:RA_LSB];
    o_rb      = i_ir[RB_MSB:RB_LSB];
    o_imm     = {{(N-6){1'b0}}, i_ir[IMM_MSB:IMM_LSB]};
    o_is_nop  = (o_opcode == OP_NOP);
    o_is_ldi  = (o_opcode == OP_LDI);
    o_is_halt = (o_opcode == OP_HALT);
    o_is_alu  = !(o_is_nop || o_is_ldi || o_is_halt);
  end
endmodule

// File: rtl/rf_seq_ctrl.sv
// Multi-cycle sequencer for the 8x16 register file and ALU.
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous reset, active HIGH despite the name
//   bus     : instruction handshake plus register-file / ALU controls
// All outputs except enable are registered from the next state and next IR.
module rf_seq_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned N           = 16,
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned CW          = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  rf_seq_ctrl_if.slave   bus
);
  state_e       r_state, w_state_d;
  logic [N-1:0] r_ir, w_ir_d;
  logic [CW-1:0] r_cnt, w_cnt_d;
  logic         r_ready, r_wb_sel, r_enable, r_done, r_halted;
  logic [2:0]   r_sel_a, r_sel_b, r_in;
  logic [3:0]   r_alu_op;
  logic [N-1:0] r_imm;

  logic         w_accept, w_busy;
  logic [2:0]   w_rd, w_ra, w_rb;
  logic [3:0]   w_opcode;
  logic [N-1:0] w_imm;
  logic         w_is_nop, w_is_ldi, w_is_halt, w_is_alu;

  assign w_accept = bus.instr_valid & r_ready;
  // Outside the capture edge the IR just recirculates, so decoding the
  // next IR also gives the current instruction in READ/EXEC/WRITE.
  assign w_ir_d   = w_accept ? bus.instr : r_ir;

  rf_instr_decode #(.N(N)) u_decode (
    .i_ir      (w_ir_d),
    .o_rd      (w_rd),
    .o_ra      (w_ra),
    .o_rb      (w_rb),
    .o_opcode  (w_opcode),
    .o_imm     (w_imm),
    .o_is_nop  (w_is_nop),
    .o_is_ldi  (w_is_ldi),
    .o_is_halt (w_is_halt),
    .o_is_alu  (w_is_alu)
  );

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      StIdle: if (w_accept) w_state_d = StRead;
      StRead: begin
        if (w_is_alu) begin
          w_state_d = StExec;
          w_cnt_d   = '0;
        end else if (w_is_ldi) begin
          w_state_d = StWrite;
        end else if (w_is_halt) begin
          w_state_d = StHalt;
        end else begin
          w_state_d = StIdle;
        end
      end
      StExec: begin
        if (r_cnt == CW'(EXEC_CYCLES - 1)) w_state_d = StWrite;
        else                               w_cnt_d   = r_cnt + 1'b1;
      end
      StWrite: w_state_d = StIdle;
      StHalt:  w_state_d = StHalt;
      default: w_state_d = StIdle;
    endcase
  end

  assign w_busy = (w_state_d == StRead) || (w_state_d == StExec) || (w_state_d == StWrite);

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      r_state  <= StIdle;
      r_ir     <= '0;
      r_cnt    <= '0;
      r_ready  <= 1'b1;
      r_sel_a  <= '0;
      r_sel_b  <= '0;
      r_alu_op <= '0;
      r_wb_sel <= 1'b0;
      r_imm    <= '0;
      r_in     <= '0;
      r_enable <= 1'b0;
      r_done   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_ir     <= w_ir_d;
      r_cnt    <= w_cnt_d;
      r_ready  <= (w_state_d == StIdle);
      r_sel_a  <= w_busy ? w_ra : 3'd0;
      r_sel_b  <= w_busy ? w_rb : 3'd0;
      r_alu_op <= w_busy ? w_opcode : 4'd0;
      r_imm    <= w_busy ? w_imm : '0;
      r_wb_sel <= (w_state_d == StWrite) && w_is_ldi;
      r_in     <= (w_state_d == StWrite) ? w_rd : 3'd0;
      r_enable <= (w_state_d == StWrite);
      // NOP and HALT retire in READ; everything else retires in WRITE
      r_done   <= (w_state_d == StWrite) ||
                  ((w_state_d == StRead) && (w_is_nop || w_is_halt));
      r_halted <= (w_state_d == StHalt);
    end
  end

  assign bus.instr_ready = r_ready;
  assign bus.sel_A       = r_sel_a;
  assign bus.sel_B       = r_sel_b;
  assign bus.alu_op      = r_alu_op;
  assign bus.wb_sel      = r_wb_sel;
  assign bus.imm         = r_imm;
  assign bus.in          = r_in;
  // Reset in the WRITE cycle must suppress the write in that same cycle
  assign bus.enable      = r_enable & ~i_rst_n;
  assign bus.done        = r_done;
  assign bus.halted      = r_halted;
endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Directed bench for rf_seq_ctrl with a small register-file model and an
// adder standing in for the ALU.
module tb_rf_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tb_init = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_en = 0;
  int   n_acc = 0;

  always #5 clk = ~clk;

  rf_seq_ctrl_if #(.N(16)) bus ();

  rf_seq_ctrl #(.N(16), .EXEC_CYCLES(2), .CW(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst),
    .bus     (bus)
  );

  logic [15:0] regs [8];
  logic [15:0] alu_res;
  assign alu_res = regs[bus.sel_A] + regs[bus.sel_B];

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'(16 * i + 1);
    end else if (bus.enable) begin
      regs[bus.in] <= bus.wb_sel ? bus.imm : alu_res;
    end
    if (bus.enable) n_en <= n_en + 1;
    if (bus.instr_valid && bus.instr_ready) n_acc <= n_acc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!bus.instr_ready && k < 30) begin
      tick();
      k++;
    end
    check_eq(tag, {31'd0, bus.instr_ready}, 32'd1);
  endtask

  task automatic check_idle_outs(input string tag);
    check_eq({tag, "_sel"}, {26'd0, bus.sel_A, bus.sel_B}, 32'd0);
    check_eq({tag, "_ctl"}, {24'd0, bus.alu_op, bus.wb_sel, bus.enable, bus.done, bus.halted},
             32'd0);
    check_eq({tag, "_in_imm"}, {13'd0, bus.in, bus.imm}, 32'd0);
    check_eq({tag, "_ready"}, {31'd0, bus.instr_ready}, 32'd1);
  endtask

  int en0, acc0;

  initial begin
    bus.instr = '0;
    bus.instr_valid = 1'b0;

    // Reset for 3 cycles
    repeat (3) tick();
    rst = 1'b0;
    tb_init = 1'b0;
    tick();
    check_idle_outs("reset");

    // ADD r3,r1,r2 with EXEC_CYCLES=2: WRITE at T+4
    bus.instr = 16'h1650;
    bus.instr_valid = 1'b1;
    check_eq("add_ready_T", {31'd0, bus.instr_ready}, 32'd1);
    tick();
    bus.instr_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check_eq($sformatf("add_sel_T%0d", c), {26'd0, bus.sel_A, bus.sel_B}, {26'd0, 3'd1, 3'd2});
      check_eq($sformatf("add_en_T%0d", c), {30'd0, bus.enable, bus.done}, 32'd0);
      tick();
    end
    check_eq("add_sel_T4", {26'd0, bus.sel_A, bus.sel_B}, {26'd0, 3'd1, 3'd2});
    check_eq("add_wr_T4", {27'd0, bus.in, bus.enable, bus.done}, {27'd0, 3'd3, 2'b11});
    check_eq("add_wbsel_T4", {31'd0, bus.wb_sel}, 32'd0);
    tick();
    check_eq("add_ready_T5", {30'd0, bus.instr_ready, bus.enable}, 32'd2);
    check_eq("add_r3", {16'd0, regs[3]}, 32'h32);

    // LDI r5,#0x2A: WRITE at T+2
    bus.instr = 16'hEB50;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    check_eq("ldi_read_imm", {16'd0, bus.imm}, 32'h2A);
    check_eq("ldi_read_en", {31'd0, bus.enable}, 32'd0);
    tick();
    check_eq("ldi_wr", {26'd0, bus.in, bus.wb_sel, bus.enable, bus.done},
             {26'd0, 3'd5, 3'b111});
    check_eq("ldi_imm", {16'd0, bus.imm}, 32'h2A);
    tick();
    check_eq("ldi_ready", {31'd0, bus.instr_ready}, 32'd1);
    check_eq("ldi_r5", {16'd0, regs[5]}, 32'h2A);

    // NOP then HALT
    en0 = n_en;
    bus.instr = 16'h0000;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    check_eq("nop_done", {30'd0, bus.done, bus.enable}, 32'd2);
    tick();
    check_eq("nop_idle", {30'd0, bus.instr_ready, bus.done}, 32'd2);
    check_eq("nop_no_en", n_en, en0);
    bus.instr = 16'hF000;
    bus.instr_valid = 1'b1;
    tick();
    check_eq("halt_done", {30'd0, bus.done, bus.halted}, 32'd2);
    for (int c = 0; c < 20; c++) begin
      tick();
      check_eq($sformatf("halted_%0d", c), {29'd0, bus.halted, bus.instr_ready, bus.done},
               32'd4);
    end
    bus.instr_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outs("halt_reset");

    // Three queued instructions with instr_valid held high
    en0 = n_en;
    acc0 = n_acc;
    bus.instr = 16'hE228;  // LDI r1,#5
    bus.instr_valid = 1'b1;
    tick();
    bus.instr = 16'h0000;  // NOP
    wait_ready("q_wait1");
    tick();
    bus.instr = 16'h1848;  // ADD r4,r1,r1
    wait_ready("q_wait2");
    tick();
    bus.instr_valid = 1'b0;
    wait_ready("q_wait3");
    check_eq("q_accepts", n_acc - acc0, 32'd3);
    check_eq("q_enables", n_en - en0, 32'd2);
    check_eq("q_r1", {16'd0, regs[1]}, 32'h5);
    check_eq("q_r4", {16'd0, regs[4]}, 32'hA);

    // Reset in the WRITE cycle of an ADD
    en0 = n_en;
    bus.instr = 16'h1650;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    repeat (3) tick();
    check_eq("rw_pre_done", {31'd0, bus.done}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rw_en_gated", {31'd0, bus.enable}, 32'd0);
    tick();
    rst = 1'b0;
    check_idle_outs("rw_after");
    check_eq("rw_no_en", n_en, en0);
    check_eq("rw_r3", {16'd0, regs[3]}, 32'h32);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
